fp_mac_pipe: RTL

- Parametrised, pipelined floating-point multiply-accumulate unit.
- Successor to the combinational FP16 multiplier: it adds a registered product stage, a running accumulator, and a valid/ready streaming handshake.
- It accumulates a stream of a*b products and emits the sum when a beat is tagged last.
- The default configuration is IEEE-754 binary16 layout. It sits between operand-fetch logic and a result sink that can apply backpressure.

---
 rtl/fp_mac_pipe_if.sv | 37 +++
 rtl/fp_mac_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_mac_pipe_if
// Streaming bundle between operand fetch, the FP MAC and the result sink.
//   a, b       : operands {sign, exp, mantissa}, W = 1+EXP_W+MAN_W bits
//   in_valid   : a/b/in_last valid
//   in_last    : final beat of the current accumulation group
//   in_ready   : beat accepted when in_valid & in_ready at a rising edge
//   out_data   : accumulated sum of a finished group
//   out_valid  : out_data valid, held until taken
//   out_ready  : sink accepts out_data when out_valid & out_ready
// Modports: master = source/sink side (testbench), slave = the MAC.
// -----------------------------------------------------------------------------
interface fp_mac_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output a, b, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  a, b, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fp_mac_pipe.sv
// -----------------------------------------------------------------------------
// fp_mac_pipe
// Pipelined floating-point multiply-accumulate (default IEEE binary16 layout).
// S1 registers a*b (normalised by at most one place, truncated); S2 adds the
// product into a running accumulator and, on a beat tagged last, presents the
// group sum on out_data and clears the accumulator. Subnormal inputs are
// treated as zero, results below the normal range flush to signed zero, and
// results at or above the top exponent saturate to signed Inf (sticky in the
// accumulator until the group ends).
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   bus       : fp_mac_pipe_if.slave (operands, handshakes, result)
//   out_flags : {underflow, overflow} of the presented group; only present
//               when the macro FP_MAC_FLAGS_EN is defined
// -----------------------------------------------------------------------------
module fp_mac_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    fp_mac_pipe_if.slave bus
`ifdef FP_MAC_FLAGS_EN
    ,
    output logic [1:0]   out_flags
`endif
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int XW   = EXP_W + 2;           // signed exponent arithmetic width
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EMAX = 2**EXP_W - 1;        // all-ones exponent (Inf)
    localparam int LZW  = $clog2(MAN_W + 2);

    // ---------------- handshake ----------------
    logic w_stall, w_accept;
    assign w_stall      = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;
    assign w_accept     = bus.in_valid & ~w_stall;

    // ---------------- S1 product (combinational part) ----------------
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [PW-1:0]    w_pm;
    logic [XW-1:0]    w_pe;
    logic [MAN_W-1:0] w_pman;
    logic             w_p_sign;
    logic [EXP_W-1:0] w_p_exp;
    logic [MAN_W-1:0] w_p_man;
`ifdef FP_MAC_FLAGS_EN
    logic             w_p_ovf, w_p_unf;
`endif

    assign w_ea   = bus.a[W-2:MAN_W];
    assign w_eb   = bus.b[W-2:MAN_W];
    assign w_pm   = {1'b1, bus.a[MAN_W-1:0]} * {1'b1, bus.b[MAN_W-1:0]};
    // Top product bit set means the significand is in [2,4): bump the exponent.
    assign w_pe   = XW'(w_ea) + XW'(w_eb) - XW'(BIAS) + XW'(w_pm[PW-1]);
    assign w_pman = w_pm[PW-1] ? w_pm[PW-2 -: MAN_W] : w_pm[PW-3 -: MAN_W];

    always_comb begin
        w_p_sign = bus.a[W-1] ^ bus.b[W-1];
        w_p_exp  = '0;
        w_p_man  = '0;
`ifdef FP_MAC_FLAGS_EN
        w_p_ovf  = 1'b0;
        w_p_unf  = 1'b0;
`endif
        if (w_ea == '0 || w_eb == '0) begin
            w_p_sign = 1'b0;                   // zero operand -> +0
        end else if ($signed(w_pe) >= $signed(XW'(EMAX))) begin
            w_p_exp  = '1;
`ifdef FP_MAC_FLAGS_EN
            w_p_ovf  = 1'b1;
`endif
        end else if ($signed(w_pe) < $signed(XW'(1))) begin
`ifdef FP_MAC_FLAGS_EN
            w_p_unf  = 1'b1;                   // flushed, sign kept
`endif
        end else begin
            w_p_exp  = w_pe[EXP_W-1:0];
            w_p_man  = w_pman;
        end
    end

    // ---------------- registers ----------------
    logic             r_s1_valid, r_s1_last, r_s1_sign;
    logic [EXP_W-1:0] r_s1_exp;
    logic [MAN_W-1:0] r_s1_man;
    logic             r_acc_sign;
    logic [EXP_W-1:0] r_acc_exp;
    logic [MAN_W-1:0] r_acc_man;
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;

    // ---------------- S2 accumulate (combinational part) ----------------
    logic             w_p_big, w_big_s;
    logic [EXP_W-1:0] w_big_e, w_sml_e, w_diff;
    logic [MAN_W-1:0] w_big_m, w_sml_m;
    logic [MAN_W:0]   w_sml_al, w_sub, w_norm;
    logic [MAN_W+1:0] w_add;
    logic [LZW-1:0]   w_lz;
    logic [XW-1:0]    w_ex;
    logic             w_s_sign;
    logic [EXP_W-1:0] w_s_exp;
    logic [MAN_W-1:0] w_s_man;
`ifdef FP_MAC_FLAGS_EN
    logic             w_s_ovf, w_s_unf;
`endif

    assign w_p_big  = {r_s1_exp, r_s1_man} > {r_acc_exp, r_acc_man};
    assign w_big_s  = w_p_big ? r_s1_sign : r_acc_sign;
    assign w_big_e  = w_p_big ? r_s1_exp  : r_acc_exp;
    assign w_big_m  = w_p_big ? r_s1_man  : r_acc_man;
    assign w_sml_e  = w_p_big ? r_acc_exp : r_s1_exp;
    assign w_sml_m  = w_p_big ? r_acc_man : r_s1_man;
    assign w_diff   = w_big_e - w_sml_e;
    assign w_sml_al = {1'b1, w_sml_m} >> w_diff;   // bits shifted out are lost
    assign w_add    = {1'b0, 1'b1, w_big_m} + {1'b0, w_sml_al};
    assign w_sub    = {1'b1, w_big_m} - w_sml_al;  // never negative: big >= small
    assign w_norm   = w_sub << w_lz;

    always_comb begin
        w_lz = '0;
        for (int i = 0; i <= MAN_W; i++) begin
            if (w_sub[i]) w_lz = LZW'(MAN_W - i);
        end
    end

    always_comb begin
        w_s_sign = r_acc_sign;
        w_s_exp  = r_acc_exp;
        w_s_man  = r_acc_man;
        w_ex     = '0;
`ifdef FP_MAC_FLAGS_EN
        w_s_ovf  = 1'b0;
        w_s_unf  = 1'b0;
`endif
        if (r_acc_exp == '1) begin
            // Inf accumulator is sticky: keep it.
        end else if (r_s1_exp == '1 || r_acc_exp == '0) begin
            // Inf product, or empty accumulator: the sum is exactly the product.
            w_s_sign = r_s1_sign;
            w_s_exp  = r_s1_exp;
            w_s_man  = r_s1_man;
        end else if (r_s1_exp == '0) begin
            // Zero product leaves the accumulator unchanged.
        end else if (r_s1_sign == r_acc_sign) begin
            w_ex     = XW'(w_big_e) + XW'(w_add[MAN_W+1]);
            w_s_sign = w_big_s;
            if (w_ex >= XW'(EMAX)) begin
                w_s_exp = '1;
                w_s_man = '0;
`ifdef FP_MAC_FLAGS_EN
                w_s_ovf = 1'b1;
`endif
            end else begin
                w_s_exp = w_ex[EXP_W-1:0];
                w_s_man = w_add[MAN_W+1] ? w_add[MAN_W:1] : w_add[MAN_W-1:0];
            end
        end else if (w_sub == '0) begin
            w_s_sign = 1'b0;                   // exact cancellation -> +0
            w_s_exp  = '0;
            w_s_man  = '0;
        end else begin
            w_ex     = XW'(w_big_e) - XW'(w_lz);
            w_s_sign = w_big_s;
            if ($signed(w_ex) < $signed(XW'(1))) begin
                w_s_exp = '0;
                w_s_man = '0;
`ifdef FP_MAC_FLAGS_EN
                w_s_unf = 1'b1;
`endif
            end else begin
                w_s_exp = w_ex[EXP_W-1:0];
                w_s_man = w_norm[MAN_W-1:0];
            end
        end
    end

    // Truncated product bits and the hidden bit after renormalisation.
    logic w_unused;
    assign w_unused = ^{w_pm[PW-MAN_W-3:0], w_norm[MAN_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_man    <= '0;
            r_acc_sign  <= 1'b0;
            r_acc_exp   <= '0;
            r_acc_man   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last <= bus.in_last;
                r_s1_sign <= w_p_sign;
                r_s1_exp  <= w_p_exp;
                r_s1_man  <= w_p_man;
            end
            // Not stalled: any presented word is taken this edge, so out_valid
            // is simply whether a new group sum loads.
            r_out_valid <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_data <= {w_s_sign, w_s_exp, w_s_man};
                    r_acc_sign <= 1'b0;
                    r_acc_exp  <= '0;
                    r_acc_man  <= '0;
                end else begin
                    r_acc_sign <= w_s_sign;
                    r_acc_exp  <= w_s_exp;
                    r_acc_man  <= w_s_man;
                end
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;

`ifdef FP_MAC_FLAGS_EN
    // Flags ride alongside the datapath: S1 keeps the product's flags, the
    // accumulator keeps the OR of the group so far.
    logic [1:0] r_s1_flags, r_acc_flags, r_out_flags;
    logic [1:0] w_grp_flags;
    assign w_grp_flags = r_acc_flags | r_s1_flags | {w_s_unf, w_s_ovf};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_flags  <= '0;
            r_acc_flags <= '0;
            r_out_flags <= '0;
        end else if (!w_stall) begin
            if (w_accept) r_s1_flags <= {w_p_unf, w_p_ovf};
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_out_flags <= w_grp_flags;
                    r_acc_flags <= '0;
                end else begin
                    r_acc_flags <= w_grp_flags;
                end
            end
        end
    end

    assign out_flags = r_out_flags;
`endif
endmodule
